ws2812_frame_sequencer: RTL and testbench



---
 rtl/ws2812_pkg.sv | 25 ++
 rtl/ws2812_frame_sequencer_if.sv | 26 ++
 rtl/ws2812_delay_counter.sv | 27 ++
 rtl/ws2812_frame_sequencer.sv | 166 ++++++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 frame sequencer slice:
// sequencer state encoding, colour channel codes and LED index sizing.
package ws2812_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_REQ,
    ST_WAIT,
    ST_SEND,
    ST_LATCH,
    ST_GAP
  } seq_state_t;

  localparam logic [1:0] CH_G = 2'd0;
  localparam logic [1:0] CH_R = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;
  localparam int BYTES_PER_LED = 3;

  // A single-LED strip still needs a one-bit index port.
  function automatic int led_width(input int num_leds);
    return (num_leds > 1) ? $clog2(num_leds) : 1;
  endfunction

endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// Byte stream from the frame sequencer to the WS2812 bit serializer,
// including the latch request that holds the line low between frames.
interface ws2812_frame_sequencer_if #(
  parameter int LED_W = 3
);
  import ws2812_pkg::*;

  logic             byte_valid;
  logic             byte_ready;
  logic [7:0]       byte_data;
  logic [1:0]       byte_channel;
  logic [LED_W-1:0] byte_led;
  logic             byte_last;
  logic             latch_active;

  modport master (
    output byte_valid, byte_data, byte_channel, byte_led, byte_last, latch_active,
    input  byte_ready
  );

  modport slave (
    input  byte_valid, byte_data, byte_channel, byte_led, byte_last, latch_active,
    output byte_ready
  );

endinterface

// File: rtl/ws2812_delay_counter.sv
// Loadable down-counter; done is high during the last cycle of a loaded
// interval, so a value of N keeps the caller in its state for N cycles.
module ws2812_delay_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == WIDTH'(1));

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// Frame-level WS2812 controller: fetches G,R,B bytes per LED from the fader,
// hands them to the serializer, then runs the latch period and frame gap.
module ws2812_frame_sequencer
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS          = 8,
  parameter int FETCH_LATENCY     = 1,
  parameter int LATCH_CYCLES      = 3000,
  parameter int FRAME_GAP         = 16,
  parameter int FRAME_COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  output logic                          frame_start,
  output logic                          src_req,
  input  logic [7:0]                    src_data,
  ws2812_frame_sequencer_if.master      byte_bus,
  output logic                          busy,
  output logic [FRAME_COUNT_WIDTH-1:0]  frame_count
);

  localparam int LED_W     = led_width(NUM_LEDS);
  localparam int MAX_A     = (LATCH_CYCLES > FETCH_LATENCY) ? LATCH_CYCLES : FETCH_LATENCY;
  localparam int MAX_DELAY = (MAX_A > FRAME_GAP) ? MAX_A : FRAME_GAP;
  localparam int CNT_W     = $clog2(MAX_DELAY + 1);
  localparam logic [LED_W-1:0] LAST_LED = LED_W'(NUM_LEDS - 1);
  localparam logic [1:0]       LAST_CH  = 2'(BYTES_PER_LED - 1);

  seq_state_t                   state_reg, state_next;
  logic [LED_W-1:0]             led_reg, led_next;
  logic [1:0]                   ch_reg, ch_next;
  logic [7:0]                   data_reg, data_next;
  logic [FRAME_COUNT_WIDTH-1:0] fc_reg, fc_next;
  logic                         frame_start_reg, frame_start_next;
  logic                         src_req_reg, src_req_next;
  logic                         valid_reg, valid_next;
  logic                         last_reg, last_next;
  logic                         latch_reg, latch_next;
  logic                         busy_reg, busy_next;
  logic                         dly_load, dly_done;
  logic [CNT_W-1:0]             dly_value;

  ws2812_delay_counter #(.WIDTH(CNT_W)) delay_counter (
    .clk        (clk),
    .rst        (rst),
    .load       (dly_load),
    .load_value (dly_value),
    .done       (dly_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      led_reg         <= '0;
      ch_reg          <= CH_G;
      data_reg        <= '0;
      fc_reg          <= '0;
      frame_start_reg <= 1'b0;
      src_req_reg     <= 1'b0;
      valid_reg       <= 1'b0;
      last_reg        <= 1'b0;
      latch_reg       <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      state_reg       <= state_next;
      led_reg         <= led_next;
      ch_reg          <= ch_next;
      data_reg        <= data_next;
      fc_reg          <= fc_next;
      frame_start_reg <= frame_start_next;
      src_req_reg     <= src_req_next;
      valid_reg       <= valid_next;
      last_reg        <= last_next;
      latch_reg       <= latch_next;
      busy_reg        <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    led_next   = led_reg;
    ch_next    = ch_reg;
    data_next  = data_reg;
    fc_next    = fc_reg;
    dly_load   = 1'b0;
    dly_value  = '0;

    case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_START;
      end
      ST_START: begin
        led_next   = '0;
        ch_next    = CH_G;
        state_next = ST_REQ;
      end
      ST_REQ: begin
        dly_load   = 1'b1;
        dly_value  = CNT_W'(FETCH_LATENCY);
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (dly_done) begin
          data_next  = src_data;
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (byte_bus.byte_ready) begin
          if (led_reg == LAST_LED && ch_reg == LAST_CH) begin
            dly_load   = 1'b1;
            dly_value  = CNT_W'(LATCH_CYCLES);
            state_next = ST_LATCH;
          end else begin
            state_next = ST_REQ;
            case (ch_reg)
              CH_G:    ch_next = CH_R;
              CH_R:    ch_next = CH_B;
              default: begin
                ch_next  = CH_G;
                led_next = led_reg + 1'b1;
              end
            endcase
          end
        end
      end
      ST_LATCH: begin
        if (dly_done) begin
          fc_next = fc_reg + 1'b1;
          if (FRAME_GAP == 0) begin
            state_next = ST_IDLE;
          end else begin
            dly_load   = 1'b1;
            dly_value  = CNT_W'(FRAME_GAP);
            state_next = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (dly_done) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they register in step with it.
    frame_start_next = (state_next == ST_START);
    src_req_next     = (state_next == ST_REQ);
    valid_next       = (state_next == ST_SEND);
    last_next        = (state_next == ST_SEND) && (led_next == LAST_LED) && (ch_next == LAST_CH);
    latch_next       = (state_next == ST_LATCH);
    busy_next        = (state_next != ST_IDLE);
  end

  assign frame_start           = frame_start_reg;
  assign src_req               = src_req_reg;
  assign busy                  = busy_reg;
  assign frame_count           = fc_reg;
  assign byte_bus.byte_valid   = valid_reg;
  assign byte_bus.byte_data    = data_reg;
  assign byte_bus.byte_channel = ch_reg;
  assign byte_bus.byte_led     = led_reg;
  assign byte_bus.byte_last    = last_reg;
  assign byte_bus.latch_active = latch_reg;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// Bench for ws2812_frame_sequencer: two configurations, a random-data fader
// model per instance and a byte/frame level scoreboard.
module tb_ws2812_frame_sequencer;

  logic       clk = 1'b0;
  logic [1:0] rst_v = 2'b11;
  logic [1:0] en_v  = 2'b00;
  logic [1:0] rdy_v = 2'b11;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instance 0: 2 LEDs, latency 1, gap 2. Instance 1: 1 LED, latency 3, no gap, 2-bit count.
  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int NL     = (gi == 0) ? 2 : 1;
    localparam int FL     = (gi == 0) ? 1 : 3;
    localparam int LC     = 4;
    localparam int FG     = (gi == 0) ? 2 : 0;
    localparam int FW     = (gi == 0) ? 16 : 2;
    localparam int LW     = (NL > 1) ? $clog2(NL) : 1;
    localparam int PERIOD = 2 + 3 * NL * (FL + 2) + LC + FG;

    logic          frame_start, src_req, busy;
    logic [7:0]    src_data = 8'h00;
    logic [FW-1:0] frame_count;

    ws2812_frame_sequencer_if #(.LED_W(LW)) bus ();
    assign bus.byte_ready = rdy_v[gi];

    ws2812_frame_sequencer #(
      .NUM_LEDS(NL), .FETCH_LATENCY(FL), .LATCH_CYCLES(LC),
      .FRAME_GAP(FG), .FRAME_COUNT_WIDTH(FW)
    ) dut (
      .clk(clk), .rst(rst_v[gi]), .enable(en_v[gi]),
      .frame_start(frame_start), .src_req(src_req), .src_data(src_data),
      .byte_bus(bus), .busy(busy), .frame_count(frame_count)
    );

    logic [7:0]     exp_q[$];
    logic [7:0]     fval = 8'h00;
    logic [7:0]     exp_b;
    logic [10+LW:0] snap;
    int idx = 0, cnt = 0, lrun = 0, gap_left = 0, since = 0, fcnt_m = 0;
    int hs_cnt = 0, fs_cnt = 0, fend_cnt = 0;
    bit outstanding = 0, in_frame = 0, en_all = 0, stall = 0;

    always @(negedge clk) begin
      if (rst_v[gi]) begin
        exp_q.delete();
        idx = 0; cnt = 0; lrun = 0; gap_left = 0; since = 0; fcnt_m = 0;
        outstanding = 0; in_frame = 0; en_all = 0; stall = 0;
        src_data = 8'h00;
      end else begin
        // Fader: the byte is valid only in the cycle FL after the request.
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) src_data = fval;
        end else begin
          src_data = ~fval;
        end
        if (src_req) begin
          check("one_outstanding", 32'(outstanding), 0);
          check("req_not_in_send", 32'(bus.byte_valid), 0);
          fval = 8'($urandom);
          cnt = FL;
          exp_q.push_back(fval);
          outstanding = 1;
        end

        if (stall) begin
          check("stall_valid", 32'(bus.byte_valid), 1);
          check("stall_hold", 32'({bus.byte_data, bus.byte_channel, bus.byte_led, bus.byte_last}), 32'(snap));
        end
        stall = 0;
        if (bus.byte_valid) begin
          if (rdy_v[gi]) begin
            if (exp_q.size() == 0) begin
              check("byte_has_request", 0, 1);
            end else begin
              exp_b = exp_q.pop_front();
              check("byte_data", 32'(bus.byte_data), 32'(exp_b));
            end
            check("byte_channel", 32'(bus.byte_channel), 32'(idx % 3));
            check("byte_led", 32'(bus.byte_led), 32'(idx / 3));
            check("byte_last", 32'(bus.byte_last), 32'(idx == 3 * NL - 1));
            idx = (idx == 3 * NL - 1) ? 0 : idx + 1;
            outstanding = 0;
            hs_cnt++;
          end else begin
            stall = 1;
            snap = {bus.byte_data, bus.byte_channel, bus.byte_led, bus.byte_last};
          end
        end

        since++;
        en_all = en_all && en_v[gi];
        if (frame_start) begin
          if (en_all) check("frame_period", 32'(since), 32'(PERIOD));
          check("frame_start_fresh", 32'(idx + exp_q.size()), 0);
          since = 0; en_all = 1; in_frame = 1; fs_cnt++;
        end
        if (bus.latch_active) begin
          lrun++;
        end else if (lrun > 0) begin
          check("latch_len", 32'(lrun), 32'(LC));
          lrun = 0; in_frame = 0; gap_left = FG;
          fcnt_m = (fcnt_m + 1) % (1 << FW);
          fend_cnt++;
        end
        check("busy", 32'(busy), 32'(in_frame || gap_left > 0));
        if (gap_left > 0) gap_left--;
        check("frame_count", 32'(frame_count), 32'(fcnt_m));
      end
    end
  end

  function automatic int count_of(input int i, input int kind);
    case (kind)
      0:       return (i == 0) ? g[0].hs_cnt : g[1].hs_cnt;
      1:       return (i == 0) ? g[0].fs_cnt : g[1].fs_cnt;
      default: return (i == 0) ? g[0].fend_cnt : g[1].fend_cnt;
    endcase
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? g[0].busy : g[1].busy;
  endfunction

  task automatic wait_idle(input int i);
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      if (!busy_of(i)) break;
    end
    check("idle_reached", 32'(busy_of(i)), 0);
  endtask

  task automatic wait_count(input int i, input int kind, input int target, input string tag);
    for (int c = 0; c < 3000; c++) begin
      if (count_of(i, kind) >= target) break;
      @(posedge clk); #1;
    end
    check(tag, 32'(count_of(i, kind) >= target), 1);
  endtask

  int base;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl0", 32'({g[0].frame_start, g[0].src_req, g[0].busy, g[0].bus.byte_valid,
                            g[0].bus.byte_last, g[0].bus.latch_active}), 0);
    check("rst_data0", 32'({g[0].bus.byte_data, g[0].bus.byte_channel, g[0].bus.byte_led}), 0);
    check("rst_fc0", 32'(g[0].frame_count), 0);
    check("rst_ctrl1", 32'({g[1].frame_start, g[1].src_req, g[1].busy, g[1].bus.byte_valid,
                            g[1].bus.latch_active, g[1].frame_count}), 0);
    rst_v = 2'b00;

    // Single frame from a one-cycle enable pulse.
    en_v[0] = 1'b1; @(posedge clk); #1; en_v[0] = 1'b0;
    wait_idle(0);
    check("t1_bytes", 32'(count_of(0, 0)), 6);
    check("t1_frame_starts", 32'(count_of(0, 1)), 1);
    check("t1_frame_count", 32'(g[0].frame_count), 1);

    // Backpressure on the second byte.
    base = count_of(0, 0);
    en_v[0] = 1'b1; @(posedge clk); #1; en_v[0] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (g[0].bus.byte_valid && count_of(0, 0) == base + 1) break;
      @(posedge clk); #1;
    end
    check("t2_at_byte2", 32'(g[0].bus.byte_valid && count_of(0, 0) == base + 1), 1);
    rdy_v[0] = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t2_stall_req", 32'(g[0].src_req), 0);
    end
    rdy_v[0] = 1'b1;
    @(posedge clk); #1;
    check("t2_resume_req", 32'(g[0].src_req), 1);
    check("t2_resume_count", 32'(count_of(0, 0)), 32'(base + 2));
    wait_idle(0);
    check("t2_frame_count", 32'(g[0].frame_count), 2);

    // Capture timing with latency 3, and a stall while the fader shows garbage.
    en_v[1] = 1'b1; @(posedge clk); #1; en_v[1] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (g[1].bus.byte_valid) break;
      @(posedge clk); #1;
    end
    rdy_v[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t3_held_data", 32'(g[1].bus.byte_data), 32'(g[1].exp_q[0]));
    rdy_v[1] = 1'b1;
    wait_idle(1);
    check("t3_bytes", 32'(count_of(1, 0)), 3);
    check("t3_frame_count", 32'(g[1].frame_count), 1);

    // Continuous frames: the monitor checks each frame_start period.
    base = count_of(0, 1);
    en_v[0] = 1'b1;
    wait_count(0, 1, base + 3, "t4_frames");
    en_v[0] = 1'b0;
    wait_idle(0);

    // Reset during the fourth byte, then restart.
    en_v[0] = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if (g[0].bus.byte_valid && g[0].bus.byte_led == 1'b1 && g[0].bus.byte_channel == 2'd0) break;
    end
    check("t5_at_byte4", 32'(g[0].bus.byte_valid), 1);
    rst_v[0] = 1'b1;
    @(posedge clk); #1;
    check("t5_rst_ctrl", 32'({g[0].frame_start, g[0].src_req, g[0].busy, g[0].bus.byte_valid,
                              g[0].bus.byte_last, g[0].bus.latch_active}), 0);
    check("t5_rst_data", 32'({g[0].bus.byte_data, g[0].bus.byte_channel, g[0].bus.byte_led}), 0);
    check("t5_rst_fc", 32'(g[0].frame_count), 0);
    rst_v[0] = 1'b0;
    base = count_of(0, 1);
    wait_count(0, 0, count_of(0, 0) + 3, "t5_restart_bytes");
    en_v[0] = 1'b0;
    wait_idle(0);
    check("t5_one_frame", 32'(count_of(0, 1) - base), 1);
    check("t5_frame_count", 32'(g[0].frame_count), 1);

    // Frame counter wrap with a 2-bit count and a single LED.
    rst_v[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t6_rst_fc", 32'(g[1].frame_count), 0);
    rst_v[1] = 1'b0;
    en_v[1] = 1'b1;
    base = count_of(1, 2);
    for (int k = 1; k <= 4; k++) begin
      wait_count(1, 2, base + k, "t6_frame_done");
      check("t6_wrap_count", 32'(g[1].frame_count), 32'(k % 4));
    end
    en_v[1] = 1'b0;
    wait_idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
